kb_answer_entry: RTL and testbench

Keyboard answer-entry stage for the arithmetic quiz. It sits between the PS/2 byte receiver and the answer-checking stage. It turns the stream of scan-code bytes into a decimal number of 0–127 and supports backspace. On Enter it presents the number as a held 7-bit `kb_result` with a one-cycle `kb_submit` strobe, which drives the checker's `new_ques` input. The live entry value is also exported for the seven-segment display.

---
 rtl/kb_answer_entry.sv | 156 +++++++++++++++
 tb/tb_kb_answer_entry.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/kb_answer_entry.sv
// Keyboard answer-entry stage: PS/2 set-2 bytes -> decimal 0..127 with backspace and Enter submit.
// Optional feature: define KB_KEYPAD_EN to accept numeric-keypad digits and keypad Enter (E0 5A).
module kb_answer_entry (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    input  logic       round_clr,
    output logic [6:0] entry_value,
    output logic [1:0] digit_count,
    output logic [6:0] kb_result,
    output logic       kb_submit,
    output logic       key_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BREAK,
        S_EXT,
        S_EXT_BREAK
    } state_t;

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BKSP  = 8'h66;
    localparam logic [7:0] CODE_ENTER = 8'h5A;

    state_t      state, state_nxt;
    logic [6:0]  entry_nxt;
    logic [1:0]  count_nxt;
    logic [6:0]  result_nxt;
    logic        submit_nxt;
    logic        err_nxt;
    logic        make_valid;
    logic        enter_req;
    logic [4:0]  digit_info;
    logic [10:0] product;

    // Returns {is_digit, value}; keypad digits only map when the feature is built in.
    function automatic logic [4:0] decode_digit(input logic [7:0] code);
        logic [4:0] info;
        info = 5'd0;
        case (code)
            8'h45: info = {1'b1, 4'd0};
            8'h16: info = {1'b1, 4'd1};
            8'h1E: info = {1'b1, 4'd2};
            8'h26: info = {1'b1, 4'd3};
            8'h25: info = {1'b1, 4'd4};
            8'h2E: info = {1'b1, 4'd5};
            8'h36: info = {1'b1, 4'd6};
            8'h3D: info = {1'b1, 4'd7};
            8'h3E: info = {1'b1, 4'd8};
            8'h46: info = {1'b1, 4'd9};
`ifdef KB_KEYPAD_EN
            8'h70: info = {1'b1, 4'd0};
            8'h69: info = {1'b1, 4'd1};
            8'h72: info = {1'b1, 4'd2};
            8'h7A: info = {1'b1, 4'd3};
            8'h6B: info = {1'b1, 4'd4};
            8'h73: info = {1'b1, 4'd5};
            8'h74: info = {1'b1, 4'd6};
            8'h6C: info = {1'b1, 4'd7};
            8'h75: info = {1'b1, 4'd8};
            8'h7D: info = {1'b1, 4'd9};
`endif
            default: info = 5'd0;
        endcase
        return info;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            entry_value <= 7'd0;
            digit_count <= 2'd0;
            kb_result   <= 7'd0;
            kb_submit   <= 1'b0;
            key_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            entry_value <= entry_nxt;
            digit_count <= count_nxt;
            kb_result   <= result_nxt;
            kb_submit   <= submit_nxt;
            key_err     <= err_nxt;
        end
    end

    // Overflow is judged on the full 11-bit product before it is cut back to 7 bits.
    always_comb begin
        state_nxt  = state;
        entry_nxt  = entry_value;
        count_nxt  = digit_count;
        result_nxt = kb_result;
        submit_nxt = 1'b0;
        err_nxt    = 1'b0;
        make_valid = 1'b0;
        enter_req  = 1'b0;
        digit_info = decode_digit(scan_code);
        product    = 11'(entry_value) * 11'd10 + 11'(digit_info[3:0]);

        if (round_clr) begin
            state_nxt = S_IDLE;
            entry_nxt = 7'd0;
            count_nxt = 2'd0;
        end else if (scan_valid) begin
            case (state)
                S_IDLE: begin
                    if (scan_code == CODE_BREAK)
                        state_nxt = S_BREAK;
                    else if (scan_code == CODE_EXT)
                        state_nxt = S_EXT;
                    else
                        make_valid = 1'b1;
                end
                S_EXT: begin
                    if (scan_code == CODE_BREAK) begin
                        state_nxt = S_EXT_BREAK;
                    end else begin
                        state_nxt = S_IDLE;
`ifdef KB_KEYPAD_EN
                        enter_req = (scan_code == CODE_ENTER);
`endif
                    end
                end
                default: state_nxt = S_IDLE;
            endcase

            if (make_valid) begin
                if (digit_info[4]) begin
                    if (digit_count < 2'd3 && product <= 11'd127) begin
                        entry_nxt = product[6:0];
                        count_nxt = digit_count + 2'd1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else if (scan_code == CODE_BKSP) begin
                    if (digit_count != 2'd0) begin
                        entry_nxt = entry_value / 7'd10;
                        count_nxt = digit_count - 2'd1;
                    end
                end else if (scan_code == CODE_ENTER) begin
                    enter_req = 1'b1;
                end
            end

            if (enter_req && digit_count != 2'd0) begin
                result_nxt = entry_value;
                submit_nxt = 1'b1;
                entry_nxt  = 7'd0;
                count_nxt  = 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_kb_answer_entry.sv
// Directed self-checking bench for kb_answer_entry; build with +define+KB_KEYPAD_EN for the keypad variant.
module tb_kb_answer_entry;

    logic       clk;
    logic       reset;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       round_clr;
    logic [6:0] entry_value;
    logic [1:0] digit_count;
    logic [6:0] kb_result;
    logic       kb_submit;
    logic       key_err;

    int checks = 0;
    int passes = 0;

    kb_answer_entry dut (
        .clk         (clk),
        .reset       (reset),
        .scan_code   (scan_code),
        .scan_valid  (scan_valid),
        .round_clr   (round_clr),
        .entry_value (entry_value),
        .digit_count (digit_count),
        .kb_result   (kb_result),
        .kb_submit   (kb_submit),
        .key_err     (key_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one byte for a single cycle and returns on the next falling edge,
    // where the outputs (including one-cycle strobes) caused by that byte are visible.
    task automatic apply_stimulus(input logic [7:0] code, input logic clr);
        @(negedge clk);
        scan_code  = code;
        scan_valid = 1'b1;
        round_clr  = clr;
        @(negedge clk);
        scan_valid = 1'b0;
        round_clr  = 1'b0;
        scan_code  = 8'h00;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    task automatic check_entry(input string tag, input int val, input int cnt);
        check_output({tag, "_value"}, 32'(entry_value), val);
        check_output({tag, "_count"}, 32'(digit_count), cnt);
    endtask

    initial begin
        reset      = 1'b1;
        scan_code  = 8'h00;
        scan_valid = 1'b0;
        round_clr  = 1'b0;
        repeat (2) @(negedge clk);
        check_output("rst_entry",  32'(entry_value), 0);
        check_output("rst_count",  32'(digit_count), 0);
        check_output("rst_result", 32'(kb_result), 0);
        check_output("rst_submit", 32'(kb_submit), 0);
        check_output("rst_err",    32'(key_err), 0);
        reset = 1'b0;

        // "15" with break codes, then Enter
        apply_stimulus(8'h16, 1'b0);
        check_entry("t1_d1", 1, 1);
        apply_stimulus(8'hF0, 1'b0);
        apply_stimulus(8'h16, 1'b0);
        check_entry("t1_brk", 1, 1);
        apply_stimulus(8'h2E, 1'b0);
        check_entry("t1_d2", 15, 2);
        apply_stimulus(8'hF0, 1'b0);
        apply_stimulus(8'h2E, 1'b0);
        apply_stimulus(8'h5A, 1'b0);
        check_output("t1_submit", 32'(kb_submit), 1);
        check_output("t1_result", 32'(kb_result), 15);
        check_entry("t1_after", 0, 0);
        apply_stimulus(8'hF0, 1'b0);
        check_output("t1_submit_once", 32'(kb_submit), 0);
        apply_stimulus(8'h5A, 1'b0);
        check_output("t1_enter_break", 32'(kb_submit), 0);

        // Overflow: 12 then 8 rejected, 7 accepted
        apply_stimulus(8'h16, 1'b0);
        apply_stimulus(8'h1E, 1'b0);
        apply_stimulus(8'h3E, 1'b0);
        check_output("ovf_err", 32'(key_err), 1);
        check_entry("ovf_hold", 12, 2);
        apply_stimulus(8'h3D, 1'b0);
        check_output("ovf_err_clear", 32'(key_err), 0);
        check_entry("ovf_127", 127, 3);
        apply_stimulus(8'h5A, 1'b0);
        check_output("ovf_result", 32'(kb_result), 127);

        // Leading zeros and fourth digit
        apply_stimulus(8'h45, 1'b0);
        apply_stimulus(8'h45, 1'b0);
        check_entry("lz_00", 0, 2);
        apply_stimulus(8'h3D, 1'b0);
        check_entry("lz_007", 7, 3);
        apply_stimulus(8'h16, 1'b0);
        check_output("fourth_err", 32'(key_err), 1);
        check_entry("fourth_hold", 7, 3);
        apply_stimulus(8'h5A, 1'b0);
        check_output("lz_result", 32'(kb_result), 7);

        // Backspace
        apply_stimulus(8'h46, 1'b0);
        apply_stimulus(8'h26, 1'b0);
        check_entry("bs_93", 93, 2);
        apply_stimulus(8'h66, 1'b0);
        check_entry("bs_9", 9, 1);
        apply_stimulus(8'h66, 1'b0);
        check_entry("bs_0", 0, 0);
        apply_stimulus(8'h66, 1'b0);
        check_entry("bs_empty", 0, 0);
        check_output("bs_empty_err", 32'(key_err), 0);
        apply_stimulus(8'h5A, 1'b0);
        check_output("empty_enter_submit", 32'(kb_submit), 0);
        check_output("empty_enter_result", 32'(kb_result), 7);

        // Clear wins over Enter
        apply_stimulus(8'h25, 1'b0);
        apply_stimulus(8'h1E, 1'b0);
        check_entry("clr_42", 42, 2);
        apply_stimulus(8'h5A, 1'b1);
        check_output("clr_submit", 32'(kb_submit), 0);
        check_output("clr_result", 32'(kb_result), 7);
        check_entry("clr_entry", 0, 0);

        // Clear wins over a rejected digit
        apply_stimulus(8'h16, 1'b0);
        apply_stimulus(8'h3E, 1'b0);
        apply_stimulus(8'h3E, 1'b1);
        check_output("clr_digit_err", 32'(key_err), 0);
        check_entry("clr_digit_entry", 0, 0);

        // Extended make and extended break are discarded
        apply_stimulus(8'hE0, 1'b0);
        apply_stimulus(8'h16, 1'b0);
        check_entry("ext_make", 0, 0);
        apply_stimulus(8'hE0, 1'b0);
        apply_stimulus(8'hF0, 1'b0);
        apply_stimulus(8'h16, 1'b0);
        check_entry("ext_break", 0, 0);
        apply_stimulus(8'h16, 1'b0);
        check_entry("ext_resume", 1, 1);

        // Reset mid-break
        apply_stimulus(8'hF0, 1'b0);
        #2 reset = 1'b1;
        @(negedge clk);
        check_output("mid_rst_entry",  32'(entry_value), 0);
        check_output("mid_rst_count",  32'(digit_count), 0);
        check_output("mid_rst_result", 32'(kb_result), 0);
        check_output("mid_rst_submit", 32'(kb_submit), 0);
        check_output("mid_rst_err",    32'(key_err), 0);
        reset = 1'b0;
        apply_stimulus(8'h16, 1'b0);
        check_entry("post_rst", 1, 1);
        apply_stimulus(8'h66, 1'b0);
        check_entry("post_rst_bs", 0, 0);

        // Keypad digit and keypad Enter
        apply_stimulus(8'h69, 1'b0);
`ifdef KB_KEYPAD_EN
        check_entry("kp_digit", 1, 1);
`else
        check_entry("kp_digit", 0, 0);
`endif
        apply_stimulus(8'hE0, 1'b0);
        apply_stimulus(8'h5A, 1'b0);
`ifdef KB_KEYPAD_EN
        check_output("kp_submit", 32'(kb_submit), 1);
        check_output("kp_result", 32'(kb_result), 1);
`else
        check_output("kp_submit", 32'(kb_submit), 0);
        check_output("kp_result", 32'(kb_result), 0);
`endif
        check_entry("kp_after", 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
